display_scan_driver: RTL and testbench
======================================

Name: display_scan_driver

Overview:
- Downstream consumer of the datapath system's 32-bit display bus.
- Captures the bus once per scan frame into a tear-free snapshot.
- Converts each of the 8 nibbles to hex seven-segment codes and time-multiplexes them onto one active-low segment bus with an active-low one-hot digit select.
- Provides optional leading-zero blanking and a freeze input for single-stepping the datapath.

Parameters:
DATAWIDTH_BUS, 32, width of display data bus; digit count is fixed at DATAWIDTH_BUS/4 = 8
DATAWIDTH_PRESCALER, 16, width of scan prescaler counter
PRESCALER_MAX, 49999, terminal count; one digit slot = PRESCALER_MAX+1 clocks (1 ms at 50 MHz)

Ports:
DISPLAY_SCAN_CLOCK_50  input  1  system clock
DISPLAY_SCAN_Reset_InLow  input  1  synchronous active-low reset
DISPLAY_SCAN_DataBUS_In  input  32  display data from datapath system output
DISPLAY_SCAN_Freeze_In  input  1  1 = hold current snapshot, ignore DataBUS_In
DISPLAY_SCAN_Blank_In  input  1  1 = enable leading-zero blanking
DISPLAY_SCAN_Seg_Out  output  7  segments {g,f,e,d,c,b,a}, active-low
DISPLAY_SCAN_Dig_Out  output  8  digit enable, active-low one-hot, bit i = nibble i
DISPLAY_SCAN_FrameTick_Out  output  1  one-cycle pulse at end of each 8-digit frame

Behaviour:
- Interface: one clock; reset is synchronous and active-low (DISPLAY_SCAN_Reset_InLow sampled on rising edge of DISPLAY_SCAN_CLOCK_50).
- Reset (Reset_InLow=0 at an edge, including mid-frame) sets:
  - prescaler=0, digit index=0, snapshot=0;
  - Seg_Out=7'h7F, Dig_Out=8'hFF, FrameTick_Out=0.
- Reset has priority over all other inputs.
- Prescaler: increments each clock; at PRESCALER_MAX it wraps to 0 on the next edge, and the digit index advances in the same edge (7 wraps to 0).
- Frame end = prescaler==PRESCALER_MAX and index==7. On that edge:
  - FrameTick_Out is registered high for exactly one cycle;
  - if Freeze_In==0, snapshot <= DataBUS_In;
  - if Freeze_In==1, snapshot is unchanged.
- Snapshot never changes at any other time, so all 8 digits of a frame show the same word.
- After reset, snapshot is 0 until the first frame end (8*(PRESCALER_MAX+1) clocks).
- Outputs are registered from current state (index, snapshot, Blank_In): Seg/Dig reflect state one cycle later. The first cycle after reset release still shows 7'h7F / 8'hFF.
- Dig_Out = ~(8'b1 << index); exactly one bit low at all times outside reset.
- Hex encoding, active-low (nibble -> code):
  - 0->40, 1->79, 2->24, 3->30, 4->19, 5->12, 6->02, 7->78
  - 8->00, 9->10, A->08, b->03, C->46, d->21, E->06, F->0E
- Blanking: with Blank_In=1, digit i (i>=1) shows 7'h7F when snapshot nibbles i..7 are all zero. Digit 0 is never blanked, so value 0 shows a single "0". Dig_Out is still driven for blanked digits.
- Blank_In and Freeze_In may change at any cycle; Blank_In takes effect on the next registered output.
- No arithmetic beyond the counters; counters wrap, never saturate.

Test Plan (PRESCALER_MAX=3 for simulation):
- Reset, hold DataBUS_In=32'h12345678, release -> Dig_Out steps FE,FD,FB,...,7F every 4 clocks. Frame 1 Seg_Out all 7'h40. After first FrameTick, digit0..7 show 00,78,02,12,19,30,24,79.
- DataBUS_In toggles 32'hAAAAAAAA/32'h55555555 every 3 clocks mid-frame -> segment codes in any one frame all equal (08 or 12); snapshot updates only on FrameTick cycle.
- Snapshot 32'h0000ABCD, Freeze_In=1, then DataBUS_In=32'hFFFFFFFF -> display keeps 0000ABCD across 3 frames. Freeze_In=0 -> F shown (0E) after next FrameTick.
- Blank_In=1 with snapshot 32'h000000F0 -> digits 2..7 give 7F, digit1 0E, digit0 40. Snapshot 0 -> only digit0 shows 40.
- Reset_InLow=0 for one cycle at index 5, prescaler 2 -> next cycle Seg=7F, Dig=FF, FrameTick=0. Scan restarts at digit0 with snapshot 0.
- Count clocks between FrameTick pulses -> exactly 32. Pulse width -> exactly 1 cycle.

Source files
------------

// File: rtl/display_scan_driver_if.sv
// rtl/display_scan_driver_if.sv - display bus, control inputs and scan outputs of display_scan_driver
interface display_scan_driver_if #(
  parameter int DATAWIDTH_BUS = 32
);
  logic [DATAWIDTH_BUS-1:0]   DISPLAY_SCAN_DataBUS_In;
  logic                       DISPLAY_SCAN_Freeze_In;
  logic                       DISPLAY_SCAN_Blank_In;
  logic [6:0]                 DISPLAY_SCAN_Seg_Out;
  logic [DATAWIDTH_BUS/4-1:0] DISPLAY_SCAN_Dig_Out;
  logic                       DISPLAY_SCAN_FrameTick_Out;

  modport master (
    output DISPLAY_SCAN_DataBUS_In,
    output DISPLAY_SCAN_Freeze_In,
    output DISPLAY_SCAN_Blank_In,
    input  DISPLAY_SCAN_Seg_Out,
    input  DISPLAY_SCAN_Dig_Out,
    input  DISPLAY_SCAN_FrameTick_Out
  );

  modport slave (
    input  DISPLAY_SCAN_DataBUS_In,
    input  DISPLAY_SCAN_Freeze_In,
    input  DISPLAY_SCAN_Blank_In,
    output DISPLAY_SCAN_Seg_Out,
    output DISPLAY_SCAN_Dig_Out,
    output DISPLAY_SCAN_FrameTick_Out
  );
endinterface

// File: rtl/display_scan_driver.sv
// rtl/display_scan_driver.sv - frame-snapshot hex seven-segment scan driver
module display_scan_driver #(
  parameter int DATAWIDTH_BUS       = 32,
  parameter int DATAWIDTH_PRESCALER = 16,
  parameter int PRESCALER_MAX       = 49999
) (
  input  logic                  DISPLAY_SCAN_CLOCK_50,
  input  logic                  DISPLAY_SCAN_Reset_InLow,
  display_scan_driver_if.slave  scan_if
);

  localparam int NUM_DIGITS = DATAWIDTH_BUS / 4;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  typedef logic [DATAWIDTH_PRESCALER-1:0] presc_t;
  typedef logic [IDX_W-1:0]               idx_t;

  localparam presc_t                PRESC_TERM = presc_t'(PRESCALER_MAX);
  localparam presc_t                PRESC_ONE  = presc_t'(1);
  localparam idx_t                  IDX_LAST   = idx_t'(NUM_DIGITS - 1);
  localparam idx_t                  IDX_ONE    = idx_t'(1);
  localparam logic [NUM_DIGITS-1:0] DIG_ONE    = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  presc_t                     presc_q, presc_d;
  idx_t                       idx_q, idx_d;
  logic [DATAWIDTH_BUS-1:0]   snap_q, snap_d;
  logic [6:0]                 seg_q, seg_d;
  logic [NUM_DIGITS-1:0]      dig_q, dig_d;
  logic                       tick_q, tick_d;

  logic                       slot_end;
  logic                       frame_end;
  logic [3:0]                 cur_nib;
  logic                       upper_zero;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0:    code = 7'h40;
      4'h1:    code = 7'h79;
      4'h2:    code = 7'h24;
      4'h3:    code = 7'h30;
      4'h4:    code = 7'h19;
      4'h5:    code = 7'h12;
      4'h6:    code = 7'h02;
      4'h7:    code = 7'h78;
      4'h8:    code = 7'h00;
      4'h9:    code = 7'h10;
      4'hA:    code = 7'h08;
      4'hB:    code = 7'h03;
      4'hC:    code = 7'h46;
      4'hD:    code = 7'h21;
      4'hE:    code = 7'h06;
      default: code = 7'h0E;
    endcase
    return code;
  endfunction

  always_comb begin
    slot_end  = (presc_q == PRESC_TERM);
    frame_end = slot_end && (idx_q == IDX_LAST);

    presc_d = slot_end ? '0 : presc_q + PRESC_ONE;
    idx_d   = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
    end

    // The snapshot only moves on the frame boundary so a frame never mixes two words.
    snap_d = snap_q;
    if (frame_end && !scan_if.DISPLAY_SCAN_Freeze_In) begin
      snap_d = scan_if.DISPLAY_SCAN_DataBUS_In;
    end
    tick_d = frame_end;

    dig_d      = ~(DIG_ONE << idx_q);
    cur_nib    = snap_q[{idx_q, 2'b00} +: 4];
    // Digit i is a leading zero when it and every more significant nibble are zero.
    upper_zero = ((snap_q >> {idx_q, 2'b00}) == '0);
    if (scan_if.DISPLAY_SCAN_Blank_In && (idx_q != '0) && upper_zero) begin
      seg_d = 7'h7F;
    end else begin
      seg_d = hex_to_seg(cur_nib);
    end
  end

  always_ff @(posedge DISPLAY_SCAN_CLOCK_50) begin
    if (!DISPLAY_SCAN_Reset_InLow) begin
      presc_q <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      seg_q   <= 7'h7F;
      dig_q   <= '1;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      tick_q  <= tick_d;
    end
  end

  assign scan_if.DISPLAY_SCAN_Seg_Out       = seg_q;
  assign scan_if.DISPLAY_SCAN_Dig_Out       = dig_q;
  assign scan_if.DISPLAY_SCAN_FrameTick_Out = tick_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// tb/tb_display_scan_driver.sv - self-checking bench for display_scan_driver
module tb_display_scan_driver;

  localparam int PM    = 3;
  localparam int SLOT  = PM + 1;
  localparam int FRAME = 8 * SLOT;

  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [6:0] SEG_12345678 [8] = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
  localparam logic [6:0] SEG_ABCD [8]     = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h40, 7'h40, 7'h40, 7'h40};

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  int          m_n;
  logic [31:0] m_snap;
  logic [6:0]  exp_seg;
  logic [7:0]  exp_dig;
  logic        exp_tick;

  display_scan_driver_if #(.DATAWIDTH_BUS(32)) dbus ();

  display_scan_driver #(
    .DATAWIDTH_BUS(32),
    .DATAWIDTH_PRESCALER(16),
    .PRESCALER_MAX(PM)
  ) dut (
    .DISPLAY_SCAN_CLOCK_50(clk),
    .DISPLAY_SCAN_Reset_InLow(rst_n),
    .scan_if(dbus)
  );

  logic [6:0] seg;
  logic [7:0] dig;
  logic       tick;
  assign seg  = dbus.DISPLAY_SCAN_Seg_Out;
  assign dig  = dbus.DISPLAY_SCAN_Dig_Out;
  assign tick = dbus.DISPLAY_SCAN_FrameTick_Out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [31:0] w, input int d, input logic bl);
    logic [3:0] nib;
    nib = w[4*d +: 4];
    if (bl && d > 0 && (w >> (4*d)) == 32'd0) return 7'h7F;
    return HEX[nib];
  endfunction

  // Outputs after edge n show the scan position reached after n-1 edges since reset.
  task automatic model_edge();
    int d;
    if (!rst_n) begin
      m_n      = 0;
      m_snap   = 32'd0;
      exp_seg  = 7'h7F;
      exp_dig  = 8'hFF;
      exp_tick = 1'b0;
    end else begin
      d        = (m_n / SLOT) % 8;
      exp_dig  = ~(8'd1 << d);
      exp_seg  = ref_seg(m_snap, d, dbus.DISPLAY_SCAN_Blank_In);
      exp_tick = ((m_n % FRAME) == FRAME - 1);
      if (exp_tick && !dbus.DISPLAY_SCAN_Freeze_In) m_snap = dbus.DISPLAY_SCAN_DataBUS_In;
      m_n++;
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dbus.DISPLAY_SCAN_DataBUS_In = 32'h12345678;
    dbus.DISPLAY_SCAN_Freeze_In  = 1'b0;
    dbus.DISPLAY_SCAN_Blank_In   = 1'b0;
    tick_clk();
    tick_clk();
    n_cmp++;
    if ({seg, dig, tick} !== {7'h7F, 8'hFF, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state seg=%h dig=%h tick=%b required 7f ff 0", seg, dig, tick);
    end
    rst_n = 1'b1;
    tick_clk();
    n_cmp++;
    if ({seg, dig, tick} !== {7'h40, 8'hFE, 1'b0}) begin
      n_fail++;
      $display("FAIL first_digit seg=%h dig=%h tick=%b required 40 fe 0", seg, dig, tick);
    end
  endtask

  task automatic test_basic_scan();
    int d;
    logic [7:0] want_dig;
    for (int c = 0; c < 2 * FRAME - 1; c++) begin
      tick_clk();
      d        = ((m_n - 1) / SLOT) % 8;
      want_dig = ~(8'd1 << d);
      n_cmp++;
      if ({seg, dig, tick} !== {exp_seg, exp_dig, exp_tick}) begin
        n_fail++;
        $display("FAIL model_basic n=%0d seg=%h dig=%h tick=%b required %h %h %b",
                 m_n, seg, dig, tick, exp_seg, exp_dig, exp_tick);
      end
      n_cmp++;
      if (dig !== want_dig) begin
        n_fail++;
        $display("FAIL dig_step n=%0d dig=%h required %h", m_n, dig, want_dig);
      end
      n_cmp++;
      if (m_n <= FRAME && seg !== 7'h40) begin
        n_fail++;
        $display("FAIL frame1_zero n=%0d seg=%h required 40", m_n, seg);
      end else if (m_n > FRAME && seg !== SEG_12345678[d]) begin
        n_fail++;
        $display("FAIL frame2_digits n=%0d seg=%h required %h", m_n, seg, SEG_12345678[d]);
      end
    end
  endtask

  task automatic test_tear_free();
    logic       win_open;
    logic       win_valid;
    logic [6:0] win_seg;
    win_open  = 1'b0;
    win_valid = 1'b0;
    win_seg   = 7'h00;
    dbus.DISPLAY_SCAN_Blank_In  = 1'b0;
    dbus.DISPLAY_SCAN_Freeze_In = 1'b0;
    dbus.DISPLAY_SCAN_DataBUS_In = 32'h55555555;
    for (int c = 0; c < 3 * FRAME + 5; c++) begin
      if (c % 3 == 0) begin
        dbus.DISPLAY_SCAN_DataBUS_In = (dbus.DISPLAY_SCAN_DataBUS_In == 32'hAAAAAAAA) ?
                                       32'h55555555 : 32'hAAAAAAAA;
      end
      tick_clk();
      n_cmp++;
      if ({seg, dig, tick} !== {exp_seg, exp_dig, exp_tick}) begin
        n_fail++;
        $display("FAIL model_tear n=%0d seg=%h dig=%h tick=%b required %h %h %b",
                 m_n, seg, dig, tick, exp_seg, exp_dig, exp_tick);
      end
      if (win_valid) begin
        n_cmp++;
        if (seg !== win_seg) begin
          n_fail++;
          $display("FAIL tear_free n=%0d seg=%h required %h", m_n, seg, win_seg);
        end
      end else if (win_open) begin
        win_seg   = seg;
        win_valid = 1'b1;
        n_cmp++;
        if (seg !== 7'h08 && seg !== 7'h12) begin
          n_fail++;
          $display("FAIL tear_code n=%0d seg=%h required 08 or 12", m_n, seg);
        end
      end
      if (tick) begin
        win_open  = 1'b1;
        win_valid = 1'b0;
      end
    end
  endtask

  task automatic test_freeze();
    int d;
    dbus.DISPLAY_SCAN_Blank_In   = 1'b0;
    dbus.DISPLAY_SCAN_Freeze_In  = 1'b0;
    dbus.DISPLAY_SCAN_DataBUS_In = 32'h0000ABCD;
    do begin
      tick_clk();
      n_cmp++;
      if ({seg, dig, tick} !== {exp_seg, exp_dig, exp_tick}) begin
        n_fail++;
        $display("FAIL model_freeze_load n=%0d seg=%h dig=%h tick=%b required %h %h %b",
                 m_n, seg, dig, tick, exp_seg, exp_dig, exp_tick);
      end
    end while (m_n % FRAME != 0);
    dbus.DISPLAY_SCAN_Freeze_In  = 1'b1;
    dbus.DISPLAY_SCAN_DataBUS_In = 32'hFFFFFFFF;
    for (int c = 0; c < 3 * FRAME; c++) begin
      tick_clk();
      d = ((m_n - 1) / SLOT) % 8;
      n_cmp++;
      if (seg !== SEG_ABCD[d] || seg !== exp_seg) begin
        n_fail++;
        $display("FAIL frozen n=%0d seg=%h required %h", m_n, seg, SEG_ABCD[d]);
      end
    end
    dbus.DISPLAY_SCAN_Freeze_In = 1'b0;
    do begin
      tick_clk();
    end while (m_n % FRAME != 0);
    for (int c = 0; c < FRAME; c++) begin
      tick_clk();
      n_cmp++;
      if (seg !== 7'h0E || {dig, tick} !== {exp_dig, exp_tick}) begin
        n_fail++;
        $display("FAIL unfrozen n=%0d seg=%h dig=%h tick=%b required 0e %h %b",
                 m_n, seg, dig, tick, exp_dig, exp_tick);
      end
    end
  endtask

  task automatic test_blanking();
    int d;
    logic [6:0] want;
    dbus.DISPLAY_SCAN_Blank_In   = 1'b1;
    dbus.DISPLAY_SCAN_Freeze_In  = 1'b0;
    dbus.DISPLAY_SCAN_DataBUS_In = 32'h000000F0;
    do begin
      tick_clk();
    end while (m_n % FRAME != 0);
    for (int c = 0; c < FRAME; c++) begin
      tick_clk();
      d    = ((m_n - 1) / SLOT) % 8;
      want = (d == 0) ? 7'h40 : (d == 1) ? 7'h0E : 7'h7F;
      n_cmp++;
      if (seg !== want || {seg, dig, tick} !== {exp_seg, exp_dig, exp_tick}) begin
        n_fail++;
        $display("FAIL blank_f0 n=%0d seg=%h dig=%h required %h %h", m_n, seg, dig, want, exp_dig);
      end
    end
    dbus.DISPLAY_SCAN_DataBUS_In = 32'h00000000;
    do begin
      tick_clk();
    end while (m_n % FRAME != 0);
    for (int c = 0; c < FRAME; c++) begin
      tick_clk();
      d    = ((m_n - 1) / SLOT) % 8;
      want = (d == 0) ? 7'h40 : 7'h7F;
      n_cmp++;
      if (seg !== want || dig !== exp_dig) begin
        n_fail++;
        $display("FAIL blank_zero n=%0d seg=%h dig=%h required %h %h", m_n, seg, dig, want, exp_dig);
      end
    end
  endtask

  task automatic test_mid_reset();
    dbus.DISPLAY_SCAN_Blank_In   = 1'b0;
    dbus.DISPLAY_SCAN_DataBUS_In = 32'h12345678;
    do begin
      tick_clk();
    end while (m_n % FRAME != 5 * SLOT + 2);
    rst_n = 1'b0;
    tick_clk();
    n_cmp++;
    if ({seg, dig, tick} !== {7'h7F, 8'hFF, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset seg=%h dig=%h tick=%b required 7f ff 0", seg, dig, tick);
    end
    rst_n = 1'b1;
    tick_clk();
    n_cmp++;
    if ({seg, dig, tick} !== {7'h40, 8'hFE, 1'b0}) begin
      n_fail++;
      $display("FAIL restart seg=%h dig=%h tick=%b required 40 fe 0", seg, dig, tick);
    end
    for (int c = 0; c < FRAME + 4; c++) begin
      tick_clk();
      n_cmp++;
      if ({seg, dig, tick} !== {exp_seg, exp_dig, exp_tick}) begin
        n_fail++;
        $display("FAIL model_restart n=%0d seg=%h dig=%h tick=%b required %h %h %b",
                 m_n, seg, dig, tick, exp_seg, exp_dig, exp_tick);
      end
    end
  endtask

  task automatic test_frame_timing();
    int   last;
    int   pulses;
    logic prev;
    last   = -1;
    pulses = 0;
    prev   = tick;
    for (int c = 0; c < 4 * FRAME; c++) begin
      tick_clk();
      if (tick) begin
        pulses++;
        n_cmp++;
        if (prev !== 1'b0) begin
          n_fail++;
          $display("FAIL tick_width cycle=%0d prev=%b required 0", c, prev);
        end
        if (last >= 0) begin
          n_cmp++;
          if (c - last != FRAME) begin
            n_fail++;
            $display("FAIL tick_period got=%0d required %0d", c - last, FRAME);
          end
        end
        last = c;
      end
      prev = tick;
    end
    n_cmp++;
    if (pulses < 3) begin
      n_fail++;
      $display("FAIL tick_count got=%0d required >=3", pulses);
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    int          sh;
    for (int c = 0; c < 800; c++) begin
      r  = $urandom;
      sh = $urandom_range(0, 8);
      dbus.DISPLAY_SCAN_DataBUS_In = r >> (4 * sh);
      dbus.DISPLAY_SCAN_Freeze_In  = ($urandom_range(0, 3) == 0);
      dbus.DISPLAY_SCAN_Blank_In   = ($urandom_range(0, 2) != 0);
      rst_n = ($urandom_range(0, 299) != 0);
      tick_clk();
      n_cmp++;
      if ({seg, dig, tick} !== {exp_seg, exp_dig, exp_tick}) begin
        n_fail++;
        $display("FAIL model_random c=%0d n=%0d seg=%h dig=%h tick=%b required %h %h %b",
                 c, m_n, seg, dig, tick, exp_seg, exp_dig, exp_tick);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    m_n    = 0;
    m_snap = 32'd0;
    test_reset();
    test_basic_scan();
    test_tear_free();
    test_freeze();
    test_blanking();
    test_mid_reset();
    test_frame_timing();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
